// File: rtl/pipe_shifter_pkg.sv
// Shared op encodings and level-split helpers for the pipelined barrel shifter.
// PIPE_SHIFTER_ROTATE_EN makes ROR/ROL legal; otherwise they report as errors.
package shifter_pkg;

    typedef enum logic [2:0] {
        OP_SRL = 3'b000,
        OP_SRA = 3'b001,
        OP_SLL = 3'b010,
        OP_ROR = 3'b011,
        OP_ROL = 3'b100
    } shift_op_e;

    function automatic int log2w(input int w);
        return $clog2(w);
    endfunction

    // Earlier stages take the extra level when levels do not divide evenly.
    function automatic int stage_nlev(input int levels, input int stages, input int s);
        return (levels / stages) + ((s < (levels % stages)) ? 1 : 0);
    endfunction

    function automatic int stage_lo(input int levels, input int stages, input int s);
        return s * (levels / stages) + ((s < (levels % stages)) ? s : (levels % stages));
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_SRL, OP_SRA, OP_SLL: ok = 1'b1;
`ifdef PIPE_SHIFTER_ROTATE_EN
            OP_ROR, OP_ROL:         ok = 1'b1;
`endif
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/pipe_shifter_if.sv
// Request/result handshake bundle for pipe_shifter; master drives requests
// and consumes results, slave is the shifter itself.
interface pipe_shifter_if #(
    parameter int WIDTH = 32
);
    localparam int AMT_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       in_op;
    logic [AMT_W-1:0] in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_err;

    modport master (
        output in_valid, in_data, in_op, in_amt, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, in_op, in_amt, out_ready,
        output in_ready, out_valid, out_data, out_err
    );

endinterface

// File: rtl/pipe_shifter_stage.sv
// One pipeline stage: applies barrel levels LO..LO+NLEV-1 and holds one entry.
// Rotate levels exist only when PIPE_SHIFTER_ROTATE_EN is defined.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = $clog2(WIDTH),
    parameter int LO    = 0,
    parameter int NLEV  = 1,
    parameter bit FIRST = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    input  logic [2:0]       up_op,
    input  logic [AMT_W-1:0] up_amt,
    input  logic             up_err,
    input  logic             dn_ready,
    output logic             dn_valid,
    output logic [WIDTH-1:0] dn_data,
    output logic [2:0]       dn_op,
    output logic [AMT_W-1:0] dn_amt,
    output logic             dn_err
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [2:0]       op_q, op_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] shifted;
    logic             err_in;

    // Illegal ops are zeroed at entry; zero survives every later level unchanged.
    always_comb begin
        shifted = up_data;
        err_in  = up_err;
        if (FIRST && !op_legal(up_op)) begin
            shifted = '0;
            err_in  = 1'b1;
        end else begin
            for (int lev = LO; lev < LO + NLEV; lev++) begin
                if (up_amt[lev]) begin
                    case (up_op)
                        OP_SRL: shifted = shifted >> (1 << lev);
                        OP_SRA: shifted = $signed(shifted) >>> (1 << lev);
                        OP_SLL: shifted = shifted << (1 << lev);
`ifdef PIPE_SHIFTER_ROTATE_EN
                        OP_ROR: shifted = (shifted >> (1 << lev)) | (shifted << (WIDTH - (1 << lev)));
                        OP_ROL: shifted = (shifted << (1 << lev)) | (shifted >> (WIDTH - (1 << lev)));
`endif
                        default: shifted = shifted;
                    endcase
                end
            end
        end
    end

    assign up_ready = !vld_q || dn_ready;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        op_d   = op_q;
        amt_d  = amt_q;
        err_d  = err_q;
        if (up_ready) begin
            vld_d = up_valid;
            if (up_valid) begin
                data_d = shifted;
                op_d   = up_op;
                amt_d  = up_amt;
                err_d  = err_in;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            op_q   <= '0;
            amt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            op_q   <= op_d;
            amt_q  <= amt_d;
            err_q  <= err_d;
        end
    end

    assign dn_valid = vld_q;
    assign dn_data  = data_q;
    assign dn_op    = op_q;
    assign dn_amt   = amt_q;
    assign dn_err   = err_q;

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter (SRL/SRA/SLL, optional ROR/ROL via PIPE_SHIFTER_ROTATE_EN)
// with valid/ready flow control and bubble collapsing across STAGES entries.
module pipe_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic          clock,
    input  logic          reset,
    pipe_shifter_if.slave bus
);

    localparam int AMT_W = log2w(WIDTH);

    // Index s is the input of stage s; index STAGES is the output of the last stage.
    logic             vld_w [0:STAGES];
    logic             rdy_w [0:STAGES];
    logic [WIDTH-1:0] data_w[0:STAGES];
    logic [2:0]       op_w  [0:STAGES];
    logic [AMT_W-1:0] amt_w [0:STAGES];
    logic             err_w [0:STAGES];

    assign vld_w[0]  = bus.in_valid;
    assign data_w[0] = bus.in_data;
    assign op_w[0]   = bus.in_op;
    assign amt_w[0]  = bus.in_amt;
    assign err_w[0]  = 1'b0;

    assign rdy_w[STAGES] = bus.out_ready;
    assign bus.in_ready  = rdy_w[0] && !reset;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        shifter_stage #(
            .WIDTH (WIDTH),
            .AMT_W (AMT_W),
            .LO    (stage_lo(AMT_W, STAGES, s)),
            .NLEV  (stage_nlev(AMT_W, STAGES, s)),
            .FIRST (s == 0)
        ) u_stage (
            .clock    (clock),
            .reset    (reset),
            .up_valid (vld_w[s]),
            .up_ready (rdy_w[s]),
            .up_data  (data_w[s]),
            .up_op    (op_w[s]),
            .up_amt   (amt_w[s]),
            .up_err   (err_w[s]),
            .dn_ready (rdy_w[s+1]),
            .dn_valid (vld_w[s+1]),
            .dn_data  (data_w[s+1]),
            .dn_op    (op_w[s+1]),
            .dn_amt   (amt_w[s+1]),
            .dn_err   (err_w[s+1])
        );
    end

    assign bus.out_valid = vld_w[STAGES];
    assign bus.out_data  = data_w[STAGES];
    assign bus.out_err   = err_w[STAGES];

    // Op and amount are only needed by downstream levels; the tail copy is dropped.
    logic unused_tail;
    assign unused_tail = ^{op_w[STAGES], amt_w[STAGES]};

endmodule

// File: tb/tb_pipe_shifter.sv
// Directed bench for pipe_shifter: vector table on a 32/2 build, back-pressure
// and reset sequences, plus sweeps on 8/3 and 64/1 builds against a reference model.
module tb_pipe_shifter;
    import shifter_pkg::*;

`ifdef PIPE_SHIFTER_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_shifter_if #(.WIDTH(32)) i32 ();
    pipe_shifter_if #(.WIDTH(8))  i8  ();
    pipe_shifter_if #(.WIDTH(64)) i64 ();

    pipe_shifter #(.WIDTH(32), .STAGES(2)) dut32 (.clock(clk), .reset(rst), .bus(i32.slave));
    pipe_shifter #(.WIDTH(8),  .STAGES(3)) dut8  (.clock(clk), .reset(rst), .bus(i8.slave));
    pipe_shifter #(.WIDTH(64), .STAGES(1)) dut64 (.clock(clk), .reset(rst), .bus(i64.slave));

    int          sel;
    logic        drv_valid, drv_oready;
    logic [2:0]  drv_op;
    logic [63:0] drv_data;
    logic [5:0]  drv_amt;

    assign i32.in_valid  = drv_valid && (sel == 0);
    assign i32.in_data   = drv_data[31:0];
    assign i32.in_op     = drv_op;
    assign i32.in_amt    = drv_amt[4:0];
    assign i32.out_ready = drv_oready;
    assign i8.in_valid   = drv_valid && (sel == 1);
    assign i8.in_data    = drv_data[7:0];
    assign i8.in_op      = drv_op;
    assign i8.in_amt     = drv_amt[2:0];
    assign i8.out_ready  = drv_oready;
    assign i64.in_valid  = drv_valid && (sel == 2);
    assign i64.in_data   = drv_data;
    assign i64.in_op     = drv_op;
    assign i64.in_amt    = drv_amt;
    assign i64.out_ready = drv_oready;

    logic        obs_iready, obs_ovalid, obs_oerr;
    logic [63:0] obs_odata;

    always_comb begin
        obs_iready = i32.in_ready;
        obs_ovalid = i32.out_valid;
        obs_oerr   = i32.out_err;
        obs_odata  = 64'(i32.out_data);
        case (sel)
            1: begin
                obs_iready = i8.in_ready;
                obs_ovalid = i8.out_valid;
                obs_oerr   = i8.out_err;
                obs_odata  = 64'(i8.out_data);
            end
            2: begin
                obs_iready = i64.in_ready;
                obs_ovalid = i64.out_valid;
                obs_oerr   = i64.out_err;
                obs_odata  = i64.out_data;
            end
            default: ;
        endcase
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: no handshake within 50 cycles, expected one", name);
    endtask

    // Whole-word reference: {err, data} with data masked to w bits.
    function automatic logic [64:0] ref_model(input int w, input logic [2:0] op,
                                              input logic [63:0] d, input int amt);
        logic [63:0] mask, x, r;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        x = d & mask;
        r = '0;
        case (op)
            3'b000: r = x >> amt;
            3'b001: begin
                r = x >> amt;
                if (x[w-1]) r = r | (mask & ~(mask >> amt));
            end
            3'b010: r = (x << amt) & mask;
            3'b011: begin
                if (!ROT) return {1'b1, 64'b0};
                r = ((x >> amt) | (x << (w - amt))) & mask;
            end
            3'b100: begin
                if (!ROT) return {1'b1, 64'b0};
                r = ((x << amt) | (x >> (w - amt))) & mask;
            end
            default: return {1'b1, 64'b0};
        endcase
        return {1'b0, r};
    endfunction

    task automatic txn(input logic [2:0] op, input logic [63:0] data, input int amt,
                       input logic [64:0] exp, input string name, input int exp_lat);
        int n, lat;
        @(posedge clk); #1;
        drv_op    = op;
        drv_data  = data;
        drv_amt   = 6'(amt);
        drv_valid = 1'b1;
        n = 0;
        while (!obs_iready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!obs_iready) begin
            drv_valid = 1'b0;
            timeout_fail({name, "_accept"});
            return;
        end
        @(posedge clk); #1;
        drv_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!obs_ovalid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!obs_ovalid) begin
            timeout_fail({name, "_result"});
            return;
        end
        check(name, {obs_oerr, obs_odata}, exp);
        check({name, "_lat"}, 65'(lat), 65'(exp_lat));
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic [4:0]  amt;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t        tbl[17];
    logic [31:0] bp_exp[3];
    int          acc, got, last_c, stale;
    logic        r;

    initial begin
        tbl[0]  = '{3'd1, 32'h80000000, 5'd4,  32'hF8000000, 1'b0};
        tbl[1]  = '{3'd0, 32'h80000000, 5'd4,  32'h08000000, 1'b0};
        tbl[2]  = '{3'd2, 32'h00000001, 5'd31, 32'h80000000, 1'b0};
        tbl[3]  = '{3'd3, 32'h00000001, 5'd1,  ROT ? 32'h80000000 : 32'h0, !ROT};
        tbl[4]  = '{3'd4, 32'h80000001, 5'd4,  ROT ? 32'h00000018 : 32'h0, !ROT};
        tbl[5]  = '{3'd7, 32'hDEADBEEF, 5'd5,  32'h0, 1'b1};
        tbl[6]  = '{3'd5, 32'h12345678, 5'd0,  32'h0, 1'b1};
        tbl[7]  = '{3'd6, 32'hFFFFFFFF, 5'd31, 32'h0, 1'b1};
        tbl[8]  = '{3'd0, 32'hA5A5A5A5, 5'd0,  32'hA5A5A5A5, 1'b0};
        tbl[9]  = '{3'd1, 32'hA5A5A5A5, 5'd0,  32'hA5A5A5A5, 1'b0};
        tbl[10] = '{3'd2, 32'hA5A5A5A5, 5'd0,  32'hA5A5A5A5, 1'b0};
        tbl[11] = '{3'd3, 32'hA5A5A5A5, 5'd0,  ROT ? 32'hA5A5A5A5 : 32'h0, !ROT};
        tbl[12] = '{3'd4, 32'hA5A5A5A5, 5'd0,  ROT ? 32'hA5A5A5A5 : 32'h0, !ROT};
        tbl[13] = '{3'd1, 32'h7FFFFFFF, 5'd31, 32'h00000000, 1'b0};
        tbl[14] = '{3'd1, 32'hFFFFFFFF, 5'd31, 32'hFFFFFFFF, 1'b0};
        tbl[15] = '{3'd0, 32'hFFFFFFFF, 5'd31, 32'h00000001, 1'b0};
        tbl[16] = '{3'd3, 32'h12345678, 5'd8,  ROT ? 32'h78123456 : 32'h0, !ROT};
        bp_exp[0] = 32'h2;
        bp_exp[1] = 32'h4;
        bp_exp[2] = 32'h8;

        sel = 0;
        drv_valid = 1'b0;
        drv_oready = 1'b1;
        drv_op = 3'd0;
        drv_data = '0;
        drv_amt = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 65'(obs_iready), 65'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 65'(obs_ovalid), 65'd0);
        check("reset_out_data_err", {obs_oerr, obs_odata}, 65'd0);

        // Vector table, one request at a time with streaming downstream
        for (int i = 0; i < 17; i++)
            txn(tbl[i].op, 64'(tbl[i].data), int'(tbl[i].amt),
                {tbl[i].exp_err, 32'h0, tbl[i].exp_data}, $sformatf("vec%0d", i), 1);

        // Back-pressure: three offers, two fit, then release
        @(posedge clk); #1;
        drv_oready = 1'b0;
        drv_op = 3'd2;
        drv_data = 64'd1;
        drv_amt = 6'd1;
        drv_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            r = obs_iready;
            @(posedge clk);
            if (r && drv_valid) acc++;
            #1;
            drv_amt = 6'(acc + 1);
        end
        check("bp_accepted", 65'(acc), 65'd2);
        @(negedge clk);
        check("bp_in_ready_low", 65'(obs_iready), 65'd0);
        check("bp_hold_0", {obs_ovalid, obs_oerr, obs_odata[62:0]}, {1'b1, 1'b0, 63'h2});
        @(negedge clk);
        check("bp_hold_1", {obs_ovalid, obs_oerr, obs_odata[62:0]}, {1'b1, 1'b0, 63'h2});
        @(posedge clk); #1;
        drv_oready = 1'b1;
        got = 0;
        last_c = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            r = obs_iready;
            if (obs_ovalid && got < 3) begin
                check($sformatf("bp_out%0d", got), {obs_oerr, obs_odata}, {1'b0, 32'h0, bp_exp[got]});
                if (got > 0) check($sformatf("bp_gap%0d", got), 65'(c), 65'(last_c + 1));
                last_c = c;
                got++;
            end
            @(posedge clk);
            if (r && drv_valid) acc++;
            #1;
            if (acc >= 3) drv_valid = 1'b0;
        end
        check("bp_result_count", 65'(got), 65'd3);

        // Reset with two entries in flight
        @(posedge clk); #1;
        drv_oready = 1'b0;
        drv_op = 3'd2;
        drv_data = 64'd1;
        drv_amt = 6'd5;
        drv_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            r = obs_iready;
            @(posedge clk);
            if (r && drv_valid) acc++;
            #1;
            if (acc >= 2) drv_valid = 1'b0;
        end
        check("rst_mid_prefill", {63'(acc), obs_ovalid}, {63'd2, 1'b1});
        rst = 1'b1;
        drv_oready = 1'b1;
        @(negedge clk);
        check("rst_mid_in_ready", 65'(obs_iready), 65'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", 65'(obs_ovalid), 65'd0);
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (obs_ovalid) stale++;
        end
        check("rst_mid_no_stale", 65'(stale), 65'd0);
        txn(3'd0, 64'hF0000000, 28, {1'b0, 64'hF}, "rst_first_req", 1);

        // Sweep, WIDTH=8 STAGES=3
        sel = 1;
        for (int op = 0; op < 8; op++)
            for (int amt = 0; amt < 8; amt++)
                for (int k = 0; k < 2; k++) begin
                    logic [63:0] d;
                    d = {$urandom, $urandom};
                    txn(3'(op), d, amt, ref_model(8, 3'(op), d, amt),
                        $sformatf("w8_op%0d_amt%0d", op, amt), 2);
                end

        // Sweep, WIDTH=64 STAGES=1
        sel = 2;
        for (int op = 0; op < 8; op++)
            for (int amt = 0; amt < 64; amt++)
                for (int k = 0; k < 2; k++) begin
                    logic [63:0] d;
                    d = (k == 0) ? {$urandom, $urandom} : {1'b1, 31'($urandom), $urandom};
                    txn(3'(op), d, amt, ref_model(64, 3'(op), d, amt),
                        $sformatf("w64_op%0d_amt%0d", op, amt), 0);
                end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
